// File: rtl/count_arbiter_if.sv
// Request/grant bundle between requesters and the shared burst counter.
// The arbiter uses the slave view; the requester side uses the master view.
interface count_arbiter_if;
   logic [3:0] req;
   logic       step;
   logic [3:0] gnt;
   logic [1:0] grant_id;
   logic [2:0] count;
   logic       busy;
   logic       done;
   logic       abort;

   modport master (
      output req, step,
      input  gnt, grant_id, count, busy, done, abort
   );

   modport slave (
      input  req, step,
      output gnt, grant_id, count, busy, done, abort
   );
endinterface

// File: rtl/count_arbiter.sv
// Round-robin arbiter for one shared 3-bit burst counter.
// A granted requester advances the counter with step until it reaches LIMIT
// (done pulse) or drops its request early (abort pulse). Every burst is
// followed by at least one IDLE cycle before the next grant is issued.
module count_arbiter #(
   parameter logic [2:0] LIMIT = 3'd5   // legal range 1..7
) (
   input  logic             clk,
   input  logic             reset_n,
   count_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] id_q, id_d;          // requester holding the current grant
   logic [1:0] last_id_q, last_id_d; // last requester served, round-robin base
   logic [2:0] count_q, count_d;
   logic       abort_q, abort_d;

   logic       pick_valid;
   logic [1:0] pick_id;

   // Round-robin search: first set req bit starting at last_id+1, wrapping mod 4
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      pick_valid = 1'b0;
      pick_id    = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         if (!pick_valid && bus.req[last_id_q + 2'(i)]) begin
            pick_valid = 1'b1;
            pick_id    = last_id_q + 2'(i);
         end
      end
   end

   // Next-state and counter logic; abort takes precedence over step in RUN
   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      last_id_d = last_id_q;
      count_d   = count_q;
      abort_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            count_d = 3'd0;
            if (pick_valid) begin
               state_d = RUN;
               id_d    = pick_id;
            end
         end

         RUN: begin
            if (!bus.req[id_q]) begin
               state_d   = IDLE;
               abort_d   = 1'b1;
               last_id_d = id_q;
               count_d   = 3'd0;
            end else if (bus.step) begin
               if (count_q == LIMIT - 3'd1) begin
                  count_d = LIMIT;
                  state_d = DONE;
               end else begin
                  count_d = count_q + 3'd1;
               end
            end
         end

         DONE: begin
            // Request level is irrelevant here: the burst already completed.
            state_d   = IDLE;
            last_id_d = id_q;
            count_d   = 3'd0;
         end

         default: begin
            state_d = IDLE;
            count_d = 3'd0;
         end
      endcase
   end

   // State register; reset leaves requester 0 first in line
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         id_q      <= 2'd0;
         last_id_q <= 2'd3;
         count_q   <= 3'd0;
         abort_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values computed above.
         state_q   <= state_d;
         id_q      <= id_d;
         last_id_q <= last_id_d;
         count_q   <= count_d;
         abort_q   <= abort_d;
      end
   end

   // Outputs decode straight from registered state, so done/abort are glitch-free pulses
   assign bus.gnt      = (state_q != IDLE) ? (4'b0001 << id_q) : 4'b0000;
   assign bus.grant_id = (state_q != IDLE) ? id_q : 2'd0;
   assign bus.count    = count_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == DONE);
   assign bus.abort    = abort_q;

endmodule

// File: tb/tb_count_arbiter.sv
// Directed bench for count_arbiter (LIMIT = 5). Each cycle pushes the
// expected post-edge outputs to a scoreboard queue and pops them once the
// DUT has settled on the following falling edge.
module tb_count_arbiter;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] grant_id;
      logic [2:0] count;
      logic       busy;
      logic       done;
      logic       abort;
   } obs_t;

   logic clk = 1'b0;
   logic reset_n;

   count_arbiter_if bus ();

   count_arbiter dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   obs_t sb_q[$];
   int   n_check = 0;
   int   n_pass  = 0;
   int   n_fail  = 0;

   // Expected outputs from a grant vector; grant_id and busy follow from it
   function automatic obs_t mk(input logic [3:0] g, input logic [2:0] c,
                               input logic d, input logic a);
      obs_t o;
      o.gnt   = g;
      o.count = c;
      o.done  = d;
      o.abort = a;
      o.busy  = (g != 4'b0000);
      case (g)
         4'b0010: o.grant_id = 2'd1;
         4'b0100: o.grant_id = 2'd2;
         4'b1000: o.grant_id = 2'd3;
         default: o.grant_id = 2'd0;
      endcase
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.gnt      = bus.gnt;
      o.grant_id = bus.grant_id;
      o.count    = bus.count;
      o.busy     = bus.busy;
      o.done     = bus.done;
      o.abort    = bus.abort;
      return o;
   endfunction

   task automatic check(input string tag, input obs_t exp_v);
      obs_t got;
      got = sample();
      n_check++;
      assert (got === exp_v) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed gnt=%b id=%0d count=%0d busy=%b done=%b abort=%b, expected gnt=%b id=%0d count=%0d busy=%b done=%b abort=%b",
                tag, got.gnt, got.grant_id, got.count, got.busy, got.done, got.abort,
                exp_v.gnt, exp_v.grant_id, exp_v.count, exp_v.busy, exp_v.done, exp_v.abort);
      end
   endtask

   // One clock: drive at the falling edge, expect e after the next rising edge
   task automatic cyc(input logic [3:0] r, input logic s, input obs_t e, input string tag);
      bus.req  = r;
      bus.step = s;
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      check(tag, sb_q.pop_front());
   endtask

   // Grant, five steps to done, then the mandatory idle cycle
   task automatic rr_burst(input logic [3:0] r, input logic [3:0] g, input string tag);
      cyc(r, 1'b0, mk(g, 3'd0, 1'b0, 1'b0), {tag, "_grant"});
      for (int i = 1; i <= 4; i++)
         cyc(r, 1'b1, mk(g, 3'(i), 1'b0, 1'b0), {tag, "_step"});
      cyc(r, 1'b1, mk(g, 3'd5, 1'b1, 1'b0), {tag, "_done"});
      cyc(r, 1'b0, mk(4'b0000, 3'd0, 1'b0, 1'b0), {tag, "_idle"});
   endtask

   initial begin
      reset_n  = 1'b0;
      bus.req  = 4'b0000;
      bus.step = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_state", mk(4'b0000, 3'd0, 1'b0, 1'b0));
      reset_n = 1'b1;

      // All requesting after reset: requester 0 first, then requester 1
      cyc(4'b1111, 1'b0, mk(4'b0001, 3'd0, 1'b0, 1'b0), "first_grant");
      for (int i = 1; i <= 4; i++)
         cyc(4'b1111, 1'b1, mk(4'b0001, 3'(i), 1'b0, 1'b0), "first_step");
      cyc(4'b1111, 1'b1, mk(4'b0001, 3'd5, 1'b1, 1'b0), "first_done");
      cyc(4'b1111, 1'b0, mk(4'b0000, 3'd0, 1'b0, 1'b0), "first_idle");
      cyc(4'b1111, 1'b0, mk(4'b0010, 3'd0, 1'b0, 1'b0), "next_grant_1");

      // Step toggling plus churn on non-granted request bits
      cyc(4'b1011, 1'b1, mk(4'b0010, 3'd1, 1'b0, 1'b0), "toggle_s1");
      cyc(4'b0010, 1'b0, mk(4'b0010, 3'd1, 1'b0, 1'b0), "toggle_s0");
      cyc(4'b1110, 1'b1, mk(4'b0010, 3'd2, 1'b0, 1'b0), "toggle_s1b");
      cyc(4'b0111, 1'b0, mk(4'b0010, 3'd2, 1'b0, 1'b0), "toggle_s0b");
      cyc(4'b0010, 1'b1, mk(4'b0010, 3'd3, 1'b0, 1'b0), "toggle_c3");
      cyc(4'b0010, 1'b1, mk(4'b0010, 3'd4, 1'b0, 1'b0), "toggle_c4");
      cyc(4'b0010, 1'b1, mk(4'b0010, 3'd5, 1'b1, 1'b0), "toggle_done");
      cyc(4'b0000, 1'b0, mk(4'b0000, 3'd0, 1'b0, 1'b0), "toggle_idle");
      cyc(4'b0000, 1'b1, mk(4'b0000, 3'd0, 1'b0, 1'b0), "idle_no_req");

      // Requester 2 drops its request at count 3 while stepping: abort wins
      cyc(4'b0100, 1'b0, mk(4'b0100, 3'd0, 1'b0, 1'b0), "r2_grant");
      for (int i = 1; i <= 3; i++)
         cyc(4'b0100, 1'b1, mk(4'b0100, 3'(i), 1'b0, 1'b0), "r2_step");
      cyc(4'b0000, 1'b1, mk(4'b0000, 3'd0, 1'b0, 1'b1), "r2_abort");
      cyc(4'b1111, 1'b0, mk(4'b1000, 3'd0, 1'b0, 1'b0), "after_abort_r3");

      // Step held high: saturate at LIMIT, single done, idle, then requester 0
      for (int i = 1; i <= 4; i++)
         cyc(4'b1111, 1'b1, mk(4'b1000, 3'(i), 1'b0, 1'b0), "hold_step");
      cyc(4'b1111, 1'b1, mk(4'b1000, 3'd5, 1'b1, 1'b0), "hold_done");
      cyc(4'b1111, 1'b1, mk(4'b0000, 3'd0, 1'b0, 1'b0), "hold_idle");
      cyc(4'b1111, 1'b1, mk(4'b0001, 3'd0, 1'b0, 1'b0), "hold_regrant");
      for (int i = 1; i <= 4; i++)
         cyc(4'b1111, 1'b1, mk(4'b0001, 3'(i), 1'b0, 1'b0), "hold_r0_step");

      // Reset mid-RUN at count 4: immediate clear, no pulses
      reset_n = 1'b0;
      #1;
      check("async_reset", mk(4'b0000, 3'd0, 1'b0, 1'b0));
      @(posedge clk);
      @(negedge clk);
      check("reset_held", mk(4'b0000, 3'd0, 1'b0, 1'b0));
      bus.step = 1'b0;
      reset_n  = 1'b1;

      // Two requesters alternate with one idle cycle between bursts
      rr_burst(4'b1001, 4'b0001, "rr_a0");
      rr_burst(4'b1001, 4'b1000, "rr_a3");
      rr_burst(4'b1001, 4'b0001, "rr_b0");
      rr_burst(4'b1001, 4'b1000, "rr_b3");

      // Request dropped during DONE: done already fired, no abort follows
      cyc(4'b1001, 1'b0, mk(4'b0001, 3'd0, 1'b0, 1'b0), "drop_grant");
      for (int i = 1; i <= 4; i++)
         cyc(4'b1001, 1'b1, mk(4'b0001, 3'(i), 1'b0, 1'b0), "drop_step");
      cyc(4'b1001, 1'b1, mk(4'b0001, 3'd5, 1'b1, 1'b0), "drop_done");
      cyc(4'b0000, 1'b0, mk(4'b0000, 3'd0, 1'b0, 1'b0), "drop_in_done");
      cyc(4'b0000, 1'b0, mk(4'b0000, 3'd0, 1'b0, 1'b0), "drop_idle");

      $display("%0d/%0d checks passed", n_pass, n_check);
      $finish;
   end

endmodule
